pin_walk_checker: RTL

Tester-side sequencer for the pin tester gateware: it drives the `TestClock` line that steps the device-under-test's walking-one shift register, and checks the 16 sensed pins of each test group after every step. It first forces the DUT into its idle-timeout reset and then walks all 128 positions, including the wrap back to position 0. It reports a pass/fail summary plus the first failing position.

---
 rtl/pin_walk_checker_if.sv | 34 +++
 rtl/pin_walk_checker.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pin_walk_checker_if.sv
// Host-side bus of the pin-walk sequencer: run control, DUT step clock,
// group routing, sensed pins and the latched run summary.
`timescale 1ns/1ps
interface pin_walk_checker_if #(
  parameter int PINCOUNT = 128,
  parameter int GROUPW   = 16
);
  localparam int IDXW = (PINCOUNT > 1) ? $clog2(PINCOUNT) : 1;
  localparam int GSW  = (PINCOUNT / GROUPW > 1) ? $clog2(PINCOUNT / GROUPW) : 1;

  logic              start;
  logic              test_clock;
  logic [GSW-1:0]    group_sel;
  logic [GROUPW-1:0] sense;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        fail_count;
  logic [IDXW-1:0]   first_fail_idx;
  logic              first_fail_valid;
  logic [GROUPW-1:0] fail_data;

  modport master (
    input  start, sense,
    output test_clock, group_sel, busy, done, pass,
           fail_count, first_fail_idx, first_fail_valid, fail_data
  );

  modport slave (
    output start, sense,
    input  test_clock, group_sel, busy, done, pass,
           fail_count, first_fail_idx, first_fail_valid, fail_data
  );
endinterface

// File: rtl/pin_walk_checker.sv
// Steps the DUT walking-one register through every position after forcing its
// idle-timeout reset, and checks each sensed test group against the expected pattern.
`timescale 1ns/1ps
module pin_walk_checker #(
  parameter int                   PINCOUNT    = 128,
  parameter int                   GROUPW      = 16,
  parameter int unsigned          RESET_HOLD  = 300_000_000,
  parameter int unsigned          HALF_PERIOD = 50,
  parameter int unsigned          SETTLE      = 32,
  parameter logic [PINCOUNT-1:0]  SKIP_MASK   = 128'h0000_0083_C000_0000_0803_0000_0080_0000
) (
  input  logic               i_clk100_p,
  input  logic               i_reset_n,
  pin_walk_checker_if.master io_bus
);
  localparam int IDXW = (PINCOUNT > 1) ? $clog2(PINCOUNT) : 1;
  localparam int KW   = IDXW + 1;
  localparam int GWL  = $clog2(GROUPW);

  localparam logic [31:0] HOLD_LAST   = 32'(RESET_HOLD - 1);
  localparam logic [31:0] HALF_LAST   = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_REL_HI, S_LO, S_SETTLE, S_SAMPLE, S_HI, S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_cnt;
  logic              r_test_clock;
  logic [IDXW-1:0]   r_p;
  logic [KW-1:0]     r_k;
  logic [GROUPW-1:0] r_sense_meta;
  logic [GROUPW-1:0] r_sense_sync;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [7:0]        r_fail_count;
  logic [IDXW-1:0]   r_first_fail_idx;
  logic              r_first_fail_valid;
  logic [GROUPW-1:0] r_fail_data;

  logic [GROUPW-1:0] w_expected;
  logic              w_mismatch;
  logic              w_last_check;
  logic [IDXW-1:0]   w_p_inc;

  // Grounded positions must read all-zero; every other position is one-hot in its group.
  assign w_expected   = SKIP_MASK[r_p] ? '0 : (GROUPW'(1) << r_p[GWL-1:0]);
  assign w_mismatch   = (r_sense_sync != w_expected);
  assign w_last_check = (r_k == KW'(PINCOUNT - 1));
  assign w_p_inc      = (r_p == IDXW'(PINCOUNT - 1)) ? '0 : r_p + IDXW'(1);

  always_ff @(posedge i_clk100_p or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.start)             w_state_next = S_HOLD;
      S_HOLD:   if (r_cnt == HOLD_LAST)       w_state_next = S_REL_HI;
      S_REL_HI: if (r_cnt == HALF_LAST)       w_state_next = S_LO;
      S_LO:     if (r_cnt == HALF_LAST)       w_state_next = S_SETTLE;
      S_SETTLE: if (r_cnt == SETTLE_LAST)     w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = w_last_check ? S_FIN : S_HI;
      S_HI:     if (r_cnt == HALF_LAST)       w_state_next = S_LO;
      S_FIN:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk100_p or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt              <= '0;
      r_test_clock       <= 1'b0;
      r_p                <= '0;
      r_k                <= '0;
      r_sense_meta       <= '0;
      r_sense_sync       <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
      r_fail_count       <= '0;
      r_first_fail_idx   <= '0;
      r_first_fail_valid <= 1'b0;
      r_fail_data        <= '0;
    end else begin
      // Phase counter restarts on every state change; TestClock follows the next phase.
      r_cnt        <= (w_state_next != r_state) ? '0 : r_cnt + 32'd1;
      r_test_clock <= (w_state_next == S_REL_HI) || (w_state_next == S_HI);
      r_sense_meta <= io_bus.sense;
      r_sense_sync <= r_sense_meta;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_busy             <= 1'b1;
            r_pass             <= 1'b0;
            r_fail_count       <= '0;
            r_first_fail_idx   <= '0;
            r_first_fail_valid <= 1'b0;
            r_fail_data        <= '0;
            r_p                <= '0;
            r_k                <= '0;
          end
        end
        S_HOLD: begin
          // The release edge also advances the DUT once, so the walk starts at 1.
          if (w_state_next == S_REL_HI) r_p <= IDXW'(1);
        end
        S_SAMPLE: begin
          if (w_mismatch) begin
            if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
            if (!r_first_fail_valid) begin
              r_first_fail_valid <= 1'b1;
              r_first_fail_idx   <= r_p;
              r_fail_data        <= r_sense_sync;
            end
          end
          r_k <= r_k + KW'(1);
          if (w_last_check) begin
            r_done <= 1'b1;
            r_pass <= (r_fail_count == 8'd0) && !w_mismatch;
          end else begin
            r_p <= w_p_inc;
          end
        end
        S_FIN:   r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign io_bus.test_clock       = r_test_clock;
  assign io_bus.group_sel        = r_p[IDXW-1:GWL];
  assign io_bus.busy             = r_busy;
  assign io_bus.done             = r_done;
  assign io_bus.pass             = r_pass;
  assign io_bus.fail_count       = r_fail_count;
  assign io_bus.first_fail_idx   = r_first_fail_idx;
  assign io_bus.first_fail_valid = r_first_fail_valid;
  assign io_bus.fail_data        = r_fail_data;
endmodule
